// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared constants and types for the fetch stage.
//   XLEN           instruction / address width
//   fetch_state_e  fetch sequencer state encoding
package pc_fetch_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // one settle cycle after reset release
    ST_FETCH = 2'd1,  // normal streaming
    ST_DRAIN = 2'd2   // waiting out a stale request after a redirect
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_if.sv
// pc_fetch_if: instruction-memory request/response bundle.
//   req    fetch -> mem  request valid
//   addr   fetch -> mem  word address, held while req=1 and no ack
//   ack    mem -> fetch  data returned this cycle
//   rdata  mem -> fetch  instruction word, valid with ack
interface pc_fetch_if
  import pc_fetch_pkg::*;
();

  logic            req;
  logic [XLEN-1:0] addr;
  logic            ack;
  logic [XLEN-1:0] rdata;

  modport master (output req, addr, input  ack, rdata);
  modport slave  (input  req, addr, output ack, rdata);

endinterface

// File: rtl/pc_fetch.sv
// pc_fetch: instruction fetch stage with a one-entry output slot.
//   clk_i, rst_n_i         clock, async active-low reset
//   stall_i                hazard hold (same net as IF_ID hold)
//   redirect_i/_addr_i     taken branch / jump target, flushes the stream
//   imem_req_o/_addr_o     instruction-memory request
//   imem_ack_i/_rdata_i    instruction-memory response
//   instr_o, pc_plus4_o    fetched word and its address + 4
//   valid_o, flush_o       slot live / bubble (flush_o = ~valid_o)
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_addr_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            valid_o,
  output logic            flush_o
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] target_q, target_d;
  // A request was raised in an earlier cycle and has not been acked yet;
  // it must be held stable regardless of stall/redirect.
  logic            pend_q, pend_d;

  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] redir_tgt;
  logic            req;
  logic            accept;
  logic            consume;

  assign pc_inc    = pc_q + XLEN'(4);          // wraps modulo 2^32
  assign redir_tgt = redirect_addr_i & ~XLEN'(3);
  assign consume   = valid_q & ~stall_i;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc4_d    = pc4_q;
    valid_d  = valid_q;
    target_d = target_q;
    req      = 1'b0;
    accept   = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_FETCH;

      ST_FETCH: begin
        req    = pend_q | ((~valid_q | ~stall_i) & ~redirect_i);
        accept = req & imem_ack_i;
        if (redirect_i) begin
          valid_d = 1'b0;
          if (pend_q & ~imem_ack_i) begin
            // Stale request still in flight: park the target until it returns.
            target_d = redir_tgt;
            state_d  = ST_DRAIN;
          end else begin
            // Nothing in flight (or it just returned and is dropped).
            pc_d = redir_tgt;
          end
        end else if (accept) begin
          instr_d = imem_rdata_i;
          pc4_d   = pc_inc;
          valid_d = 1'b1;
          pc_d    = pc_inc;
        end else if (consume) begin
          valid_d = 1'b0;
        end
      end

      ST_DRAIN: begin
        // Old request stays up until acked; its data is thrown away.
        req = 1'b1;
        if (redirect_i) target_d = redir_tgt;
        if (imem_ack_i) begin
          pc_d    = redirect_i ? redir_tgt : target_q;
          state_d = ST_FETCH;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    pend_d = req & ~imem_ack_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      pc4_q    <= '0;
      valid_q  <= 1'b0;
      target_q <= RESET_PC;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc4_q    <= pc4_d;
      valid_q  <= valid_d;
      target_q <= target_d;
      pend_q   <= pend_d;
    end
  end

  assign imem_req_o  = req;
  assign imem_addr_o = pc_q;
  assign instr_o     = instr_q;
  assign pc_plus4_o  = pc4_q;
  assign valid_o     = valid_q;
  assign flush_o     = ~valid_q;

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: scenario tasks drive the fetch stage cycle by cycle; kept
// instruction words are pushed to a scoreboard and popped when the slot is
// consumed (valid_o=1, stall_i=0).
module tb_pc_fetch;
  import pc_fetch_pkg::*;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redir_addr = '0;
  logic [31:0] instr, pc4;
  logic        valid, flush;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];

  pc_fetch_if imem();

  pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall),
    .redirect_i(redirect), .redirect_addr_i(redir_addr),
    .imem_req_o(imem.req), .imem_addr_o(imem.addr),
    .imem_ack_i(imem.ack), .imem_rdata_i(imem.rdata),
    .instr_o(instr), .pc_plus4_o(pc4), .valid_o(valid), .flush_o(flush)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a << 8) ^ 32'hC0DE_0013;
  endfunction

  // Scoreboard: every consumed slot must match the oldest kept fetch.
  always @(negedge clk) begin
    if (rst_n && valid && !stall) begin
      checks++;
      if (sb.size() == 0) begin
        failures++; $display("FAIL sb_underflow: got instr %h with nothing expected", instr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (instr !== e.instr || pc4 !== e.pc4) begin
          failures++;
          $display("FAIL sb_slot: got instr=%h pc4=%h expected instr=%h pc4=%h", instr, pc4, e.instr, e.pc4);
        end
      end
    end
  end

  // One cycle: drive after the rising edge, return at the falling edge.
  task automatic step(input logic st, input logic rd, input logic [31:0] ra,
                      input logic ack, input logic [31:0] rdata);
    @(posedge clk); #1;
    stall = st; redirect = rd; redir_addr = ra; imem.ack = ack; imem.rdata = rdata;
    @(negedge clk);
  endtask

  // Leaves the bench at the falling edge of the IDLE cycle.
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; stall = 0; redirect = 0; redir_addr = '0; imem.ack = 0; imem.rdata = '0;
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    imem.ack = 1'b1; imem.rdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    checks++; if (imem.req !== 1'b0) begin failures++; $display("FAIL rst_req: got %b expected 0", imem.req); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b expected 0", valid); end
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL rst_flush: got %b expected 1", flush); end
    checks++; if (instr !== 32'h0) begin failures++; $display("FAIL rst_instr: got %h expected 0", instr); end
    checks++; if (pc4 !== 32'h0) begin failures++; $display("FAIL rst_pc4: got %h expected 0", pc4); end
    checks++; if (imem.addr !== 32'h0) begin failures++; $display("FAIL rst_addr: got %h expected 0", imem.addr); end
  endtask

  task automatic test_stream();
    do_reset();
    checks++; if (imem.req !== 1'b0 || imem.addr !== 32'h0) begin failures++; $display("FAIL idle_req: got req=%b addr=%h expected 0/0", imem.req, imem.addr); end
    step(0, 0, 0, 1, memf(32'h0)); sb.push_back('{memf(32'h0), 32'h4});
    checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h0 || valid !== 1'b0) begin failures++; $display("FAIL stream_c2: got req=%b addr=%h valid=%b expected 1/0/0", imem.req, imem.addr, valid); end
    step(0, 0, 0, 1, memf(32'h4)); sb.push_back('{memf(32'h4), 32'h8});
    checks++; if (imem.addr !== 32'h4 || valid !== 1'b1 || pc4 !== 32'h4) begin failures++; $display("FAIL stream_c3: got addr=%h valid=%b pc4=%h expected 4/1/4", imem.addr, valid, pc4); end
    step(0, 0, 0, 1, memf(32'h8)); sb.push_back('{memf(32'h8), 32'hC});
    checks++; if (imem.addr !== 32'h8) begin failures++; $display("FAIL stream_c4: got addr=%h expected 8", imem.addr); end
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    checks++; if (valid !== 1'b0 || flush !== 1'b1 || imem.req !== 1'b1 || imem.addr !== 32'hC) begin failures++; $display("FAIL stream_wait: got valid=%b flush=%b req=%b addr=%h expected 0/1/1/c", valid, flush, imem.req, imem.addr); end
    step(0, 0, 0, 1, memf(32'hC)); sb.push_back('{memf(32'hC), 32'h10});
    step(0, 0, 0, 0, 0);
    #1; checks++; if (sb.size() != 0) begin failures++; $display("FAIL stream_drain: got %0d left expected 0", sb.size()); end
  endtask

  task automatic test_stall();
    do_reset();
    step(0, 0, 0, 1, 32'h8C01_0004); sb.push_back('{32'h8C01_0004, 32'h4});
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 1, memf(32'h4));
      checks++;
      if (instr !== 32'h8C01_0004 || pc4 !== 32'h4 || imem.addr !== 32'h4 || imem.req !== 1'b0 || valid !== 1'b1) begin
        failures++; $display("FAIL stall_hold%0d: got instr=%h pc4=%h addr=%h req=%b valid=%b expected 8c010004/4/4/0/1", i, instr, pc4, imem.addr, imem.req, valid);
      end
    end
    step(0, 0, 0, 1, memf(32'h4)); sb.push_back('{memf(32'h4), 32'h8});
    checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h4) begin failures++; $display("FAIL stall_resume: got req=%b addr=%h expected 1/4", imem.req, imem.addr); end
    step(0, 0, 0, 0, 0);
    checks++; if (imem.addr !== 32'h8) begin failures++; $display("FAIL stall_next: got addr=%h expected 8", imem.addr); end
    #1; checks++; if (sb.size() != 0) begin failures++; $display("FAIL stall_drain: got %0d left expected 0", sb.size()); end
  endtask

  task automatic test_redirect();
    do_reset();
    step(0, 0, 0, 1, memf(32'h0)); sb.push_back('{memf(32'h0), 32'h4});
    step(0, 0, 0, 1, memf(32'h4)); sb.push_back('{memf(32'h4), 32'h8});
    step(0, 1, 32'h42, 1, 32'hDEAD_BEEF);
    checks++; if (imem.req !== 1'b0) begin failures++; $display("FAIL redir_req: got %b expected 0", imem.req); end
    step(0, 0, 0, 1, memf(32'h40)); sb.push_back('{memf(32'h40), 32'h44});
    checks++; if (valid !== 1'b0 || flush !== 1'b1 || imem.addr !== 32'h40 || imem.req !== 1'b1) begin failures++; $display("FAIL redir_bubble: got valid=%b flush=%b addr=%h req=%b expected 0/1/40/1", valid, flush, imem.addr, imem.req); end
    step(0, 0, 0, 0, 0);
    checks++; if (flush !== 1'b0 || pc4 !== 32'h44) begin failures++; $display("FAIL redir_after: got flush=%b pc4=%h expected 0/44", flush, pc4); end
    #1; checks++; if (sb.size() != 0) begin failures++; $display("FAIL redir_drain: got %0d left expected 0", sb.size()); end
  endtask

  task automatic test_drain();
    do_reset();
    step(0, 0, 0, 0, 0);
    checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h0) begin failures++; $display("FAIL drain_raise: got req=%b addr=%h expected 1/0", imem.req, imem.addr); end
    step(0, 1, 32'h100, 0, 0);
    checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h0) begin failures++; $display("FAIL drain_wait: got req=%b addr=%h expected 1/0", imem.req, imem.addr); end
    step(0, 0, 0, 1, 32'hBAD0_0000);
    checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h0 || valid !== 1'b0) begin failures++; $display("FAIL drain_ack: got req=%b addr=%h valid=%b expected 1/0/0", imem.req, imem.addr, valid); end
    step(0, 0, 0, 0, 0);
    checks++; if (valid !== 1'b0 || imem.req !== 1'b1 || imem.addr !== 32'h100) begin failures++; $display("FAIL drain_target: got valid=%b req=%b addr=%h expected 0/1/100", valid, imem.req, imem.addr); end
    step(0, 0, 0, 1, memf(32'h100)); sb.push_back('{memf(32'h100), 32'h104});
    step(0, 0, 0, 0, 0);
    checks++; if (imem.addr !== 32'h104) begin failures++; $display("FAIL drain_next: got addr=%h expected 104", imem.addr); end
    // Second redirect while draining replaces the parked target.
    step(0, 1, 32'h203, 0, 0);
    step(0, 1, 32'h301, 0, 0);
    checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h104 || valid !== 1'b0) begin failures++; $display("FAIL drain_hold2: got req=%b addr=%h valid=%b expected 1/104/0", imem.req, imem.addr, valid); end
    step(0, 0, 0, 1, 32'h0BAD_0BAD);
    step(0, 0, 0, 0, 0);
    checks++; if (valid !== 1'b0 || imem.addr !== 32'h300 || imem.req !== 1'b1) begin failures++; $display("FAIL drain_overwrite: got valid=%b addr=%h req=%b expected 0/300/1", valid, imem.addr, imem.req); end
    #1; checks++; if (sb.size() != 0) begin failures++; $display("FAIL drain_left: got %0d left expected 0", sb.size()); end
  endtask

  task automatic test_wrap();
    do_reset();
    step(0, 1, 32'hFFFF_FFFF, 1, 32'h1234_5678);
    checks++; if (imem.req !== 1'b0) begin failures++; $display("FAIL wrap_redir_req: got %b expected 0", imem.req); end
    step(0, 0, 0, 1, memf(32'hFFFF_FFFC)); sb.push_back('{memf(32'hFFFF_FFFC), 32'h0});
    checks++; if (imem.addr !== 32'hFFFF_FFFC || imem.req !== 1'b1) begin failures++; $display("FAIL wrap_addr: got addr=%h req=%b expected fffffffc/1", imem.addr, imem.req); end
    step(0, 0, 0, 0, 0);
    checks++; if (valid !== 1'b1 || pc4 !== 32'h0 || imem.addr !== 32'h0) begin failures++; $display("FAIL wrap_pc4: got valid=%b pc4=%h addr=%h expected 1/0/0", valid, pc4, imem.addr); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(0, 0, 0, 1, memf(32'h0)); sb.push_back('{memf(32'h0), 32'h4});
    step(0, 0, 0, 0, 0);
    checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h4) begin failures++; $display("FAIL mid_pending: got req=%b addr=%h expected 1/4", imem.req, imem.addr); end
    #1; rst_n = 1'b0; sb.delete();
    #1;
    checks++; if (imem.req !== 1'b0 || valid !== 1'b0 || flush !== 1'b1) begin failures++; $display("FAIL mid_async: got req=%b valid=%b flush=%b expected 0/0/1", imem.req, valid, flush); end
    checks++; if (instr !== 32'h0 || pc4 !== 32'h0 || imem.addr !== 32'h0) begin failures++; $display("FAIL mid_clear: got instr=%h pc4=%h addr=%h expected 0/0/0", instr, pc4, imem.addr); end
    @(posedge clk); #1;
    rst_n = 1'b1; imem.ack = 1'b1; imem.rdata = 32'hBAAD_F00D;  // stray late ack
    @(negedge clk);
    checks++; if (imem.req !== 1'b0 || valid !== 1'b0) begin failures++; $display("FAIL mid_stray_idle: got req=%b valid=%b expected 0/0", imem.req, valid); end
    step(0, 0, 0, 0, 0);
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL mid_stray_valid: got %b expected 0", valid); end
  endtask

  initial begin
    imem.ack = 1'b0;
    imem.rdata = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_drain();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
